// File: rtl/keyed_mux_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : keyed_mux_reg_if
// Brief    : Bus bundle for keyed_mux_reg: lookup inputs, write enable, results.
// Revision : 1.0
// ============================================================================
interface keyed_mux_reg_if #(
   parameter int NR_KEY   = 2,
   parameter int KEY_LEN  = 1,
   parameter int DATA_LEN = 32
) ();
   logic                                 wen;
   logic [KEY_LEN-1:0]                   key;
   logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut;
   logic [DATA_LEN-1:0]                  default_val;
   logic [DATA_LEN-1:0]                  mux_out;
   logic                                 hit;
   logic [DATA_LEN-1:0]                  dout;

   modport master (
      output wen, key, lut, default_val,
      input  mux_out, hit, dout
   );

   modport slave (
      input  wen, key, lut, default_val,
      output mux_out, hit, dout
   );
endinterface
`default_nettype wire

// File: rtl/keyed_mux_reg.sv
`default_nettype none
// ============================================================================
// Module   : keyed_mux_reg
// Brief    : Key/value lookup mux (lowest matching index wins) feeding a
//            write-enabled register with asynchronous reset.
// Revision : 1.0
// ============================================================================
module keyed_mux_reg #(
   parameter int                  NR_KEY    = 2,
   parameter int                  KEY_LEN   = 1,
   parameter int                  DATA_LEN  = 32,
   parameter logic [DATA_LEN-1:0] RESET_VAL = 32'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   keyed_mux_reg_if.slave  bus
);
   localparam int c_PAIR_LEN = KEY_LEN + DATA_LEN;

   logic [KEY_LEN-1:0]  w_keys [NR_KEY];
   logic [DATA_LEN-1:0] w_data [NR_KEY];
   logic [DATA_LEN-1:0] w_mux_out;
   logic                w_hit;
   logic [DATA_LEN-1:0] r_dout;

   // Entry 0 sits at the MSBs so the lut reads like {k0,d0,k1,d1,...}.
   generate
      for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_unpack
         assign w_keys[gi] = bus.lut[(NR_KEY-gi)*c_PAIR_LEN-1 -: KEY_LEN];
         assign w_data[gi] = bus.lut[(NR_KEY-gi)*c_PAIR_LEN-KEY_LEN-1 -: DATA_LEN];
      end
   endgenerate

   // Scan from the highest index down so the lowest matching index lands last.
   always_comb begin
      w_hit     = 1'b0;
      w_mux_out = bus.default_val;
      for (int i = NR_KEY - 1; i >= 0; i--) begin
         if (w_keys[i] == bus.key) begin
            w_hit     = 1'b1;
            w_mux_out = w_data[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dout <= RESET_VAL;
      end else if (bus.wen) begin
         r_dout <= w_mux_out;
      end
   end

   assign bus.mux_out = w_mux_out;
   assign bus.hit     = w_hit;
   assign bus.dout    = r_dout;
endmodule
`default_nettype wire

// File: tb/tb_keyed_mux_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_keyed_mux_reg
// Brief    : Directed, table-driven self-checking bench for keyed_mux_reg.
// Revision : 1.0
// ============================================================================
module tb_keyed_mux_reg;
   logic clk;
   logic rst;

   int n_tests;
   int n_fail;

   keyed_mux_reg_if #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(32)) bus_a ();
   keyed_mux_reg_if #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(32)) bus_b ();

   keyed_mux_reg #(
      .NR_KEY(2), .KEY_LEN(1), .DATA_LEN(32), .RESET_VAL(32'h8000_0000)
   ) u_dut_a (
      .clk(clk), .rst(rst), .bus(bus_a)
   );

   keyed_mux_reg #(
      .NR_KEY(3), .KEY_LEN(2), .DATA_LEN(32), .RESET_VAL(32'h0000_1000)
   ) u_dut_b (
      .clk(clk), .rst(rst), .bus(bus_b)
   );

   typedef struct {
      logic [65:0] lut;
      logic        key;
      logic [31:0] dflt;
      logic        wen;
      logic [31:0] exp_mux;
      logic        exp_hit;
   } vec_a_t;

   typedef struct {
      logic [101:0] lut;
      logic [1:0]   key;
      logic [31:0]  dflt;
      logic         wen;
      logic [31:0]  exp_mux;
      logic         exp_hit;
   } vec_b_t;

   vec_a_t va [7];
   vec_b_t vb [7];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] exp_dout;
      logic        k;

      n_tests = 0;
      n_fail  = 0;

      va[0] = '{ {1'b0, 32'h8000_0004, 1'b1, 32'h8000_0100}, 1'b0, 32'h0, 1'b1, 32'h8000_0004, 1'b1 };
      va[1] = '{ {1'b0, 32'h8000_0004, 1'b1, 32'h8000_0100}, 1'b1, 32'h0, 1'b1, 32'h8000_0100, 1'b1 };
      va[2] = '{ {1'b0, 32'h8000_0004, 1'b1, 32'h8000_0100}, 1'b0, 32'h0, 1'b0, 32'h8000_0004, 1'b1 };
      va[3] = '{ {1'b1, 32'hAAAA_0000, 1'b1, 32'hBBBB_0000}, 1'b1, 32'h0, 1'b1, 32'hAAAA_0000, 1'b1 };
      va[4] = '{ {1'b1, 32'hAAAA_0000, 1'b1, 32'hBBBB_0000}, 1'b0, 32'h5555_AAAA, 1'b1, 32'h5555_AAAA, 1'b0 };
      va[5] = '{ {1'b0, 32'h1111_1111, 1'b0, 32'h2222_2222}, 1'b0, 32'h3333_3333, 1'b1, 32'h1111_1111, 1'b1 };
      va[6] = '{ {1'b1, 32'h1111_1111, 1'b0, 32'h2222_2222}, 1'b0, 32'h3333_3333, 1'b1, 32'h2222_2222, 1'b1 };

      vb[0] = '{ {2'b00, 32'hA000_0000, 2'b01, 32'hA000_0001, 2'b10, 32'hA000_0002}, 2'b11, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0 };
      vb[1] = '{ {2'b00, 32'hA000_0000, 2'b01, 32'hA000_0001, 2'b10, 32'hA000_0002}, 2'b11, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0 };
      vb[2] = '{ {2'b00, 32'hA000_0000, 2'b01, 32'hA000_0001, 2'b10, 32'hA000_0002}, 2'b10, 32'hDEAD_BEEF, 1'b1, 32'hA000_0002, 1'b1 };
      vb[3] = '{ {2'b00, 32'hA000_0000, 2'b01, 32'hA000_0001, 2'b10, 32'hA000_0002}, 2'b01, 32'hDEAD_BEEF, 1'b1, 32'hA000_0001, 1'b1 };
      vb[4] = '{ {2'b00, 32'hA000_0000, 2'b01, 32'hA000_0001, 2'b10, 32'hA000_0002}, 2'b00, 32'hDEAD_BEEF, 1'b0, 32'hA000_0000, 1'b1 };
      vb[5] = '{ {2'b11, 32'hC000_0000, 2'b01, 32'hC000_0001, 2'b11, 32'hC000_0002}, 2'b11, 32'h0, 1'b1, 32'hC000_0000, 1'b1 };
      vb[6] = '{ {2'b11, 32'hC000_0000, 2'b01, 32'hC000_0001, 2'b11, 32'hC000_0002}, 2'b10, 32'h0, 1'b1, 32'h0000_0000, 1'b0 };

      rst = 1'b1;
      bus_a.wen = 1'b0; bus_a.key = 1'b0; bus_a.lut = '0; bus_a.default_val = '0;
      bus_b.wen = 1'b0; bus_b.key = 2'b00; bus_b.lut = '0; bus_b.default_val = '0;

      #2;
      check("reset_a_dout", bus_a.dout, 32'h8000_0000);
      check("reset_b_dout", bus_b.dout, 32'h0000_1000);

      @(negedge clk);
      rst = 1'b0;

      // Instance B: 3 entries, 2-bit keys, miss/hold first.
      exp_dout = 32'h0000_1000;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         bus_b.lut = vb[i].lut; bus_b.key = vb[i].key;
         bus_b.default_val = vb[i].dflt; bus_b.wen = vb[i].wen;
         #1;
         check($sformatf("b_mux[%0d]", i), bus_b.mux_out, vb[i].exp_mux);
         check($sformatf("b_hit[%0d]", i), {31'b0, bus_b.hit}, {31'b0, vb[i].exp_hit});
         if (vb[i].wen) exp_dout = vb[i].exp_mux;
         tick();
         check($sformatf("b_dout[%0d]", i), bus_b.dout, exp_dout);
      end
      @(negedge clk);
      bus_b.wen = 1'b0;

      // Instance A: default next-PC configuration.
      exp_dout = 32'h8000_0000;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         bus_a.lut = va[i].lut; bus_a.key = va[i].key;
         bus_a.default_val = va[i].dflt; bus_a.wen = va[i].wen;
         #1;
         check($sformatf("a_mux[%0d]", i), bus_a.mux_out, va[i].exp_mux);
         check($sformatf("a_hit[%0d]", i), {31'b0, bus_a.hit}, {31'b0, va[i].exp_hit});
         if (va[i].wen) exp_dout = va[i].exp_mux;
         tick();
         check($sformatf("a_dout[%0d]", i), bus_a.dout, exp_dout);
      end

      // Asynchronous reset mid-cycle, away from any clock edge.
      @(negedge clk);
      bus_a.lut = {1'b0, 32'h1234_5678, 1'b1, 32'h8000_0100};
      bus_a.key = 1'b0; bus_a.wen = 1'b1;
      tick();
      check("pre_reset_dout", bus_a.dout, 32'h1234_5678);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_dout", bus_a.dout, 32'h8000_0000);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("reset_hold[%0d]", i), bus_a.dout, 32'h8000_0000);
      end

      // Reset released on the same timestep as a rising edge: that edge is ignored.
      @(negedge clk);
      bus_a.lut = {1'b0, 32'h8000_0004, 1'b1, 32'h8000_0100};
      bus_a.key = 1'b1; bus_a.wen = 1'b1;
      @(posedge clk);
      rst <= 1'b0;
      #1;
      check("race_edge_dout", bus_a.dout, 32'h8000_0000);
      tick();
      check("race_next_dout", bus_a.dout, 32'h8000_0100);

      // Toggling key each cycle: dout follows with a one-cycle lag.
      k = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         k = ~k;
         bus_a.key = k;
         #1;
         check($sformatf("toggle_lag[%0d]", i), bus_a.dout, k ? 32'h8000_0004 : 32'h8000_0100);
         tick();
         check($sformatf("toggle_dout[%0d]", i), bus_a.dout, k ? 32'h8000_0100 : 32'h8000_0004);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/keyed_mux_reg.md
Name: keyed_mux_reg

Overview:
- Parameterised key/value lookup multiplexer feeding a write-enabled state register.
- Used as the next-PC path in the fetch unit: key = jump_en, LUT entries = {0: snpc, 1: dnpc}, register holds npc/pc.
- The mux output is combinational and also exported. The register captures the mux output on the clock edge when enabled.

Parameters:
- NR_KEY, 2, number of LUT entries (>=1).
- KEY_LEN, 1, key width in bits (>=1).
- DATA_LEN, 32, data width in bits (>=1).
- RESET_VAL, 32'h80000000, register value after reset (DATA_LEN bits; default = MBASE).

Ports:
- clk  in  1  clock; the register samples on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wen  in  1  register write enable.
- key  in  KEY_LEN  lookup key.
- lut  in  NR_KEY*(KEY_LEN+DATA_LEN)  packed {key,data} pairs.
- default_val  in  DATA_LEN  mux result when no entry matches.
- mux_out  out  DATA_LEN  combinational lookup result.
- hit  out  1  combinational; 1 when any entry key equals key.
- dout  out  DATA_LEN  registered value.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.

LUT packing:
- The pair width is P = KEY_LEN+DATA_LEN.
- Entry i (0-based) occupies lut[(NR_KEY-i)*P-1 -: P], so entry 0 is at the MSBs.
- This matches concatenation order {k0,d0,k1,d1,...}.
- Within a pair, the key is the upper KEY_LEN bits and the data is the lower DATA_LEN bits.

Lookup (purely combinational, zero latency):
- The entry matches when its key equals key (full-width compare, all bits).
- mux_out = data of the lowest-index matching entry.
- When duplicate keys exist, the lowest index wins.
- No match -> mux_out = default_val and hit = 0.
- Any match -> hit = 1.
- mux_out and hit follow any change of key, lut or default_val in the same delta with no state.
- No X propagation from unmatched entries. X on key yields default_val or X at simulator discretion; there is no requirement on X-key behaviour.

Register:
- rst=1, at any time and independent of clk: dout = RESET_VAL immediately, and it is held while rst=1.
- rst=0, rising clk, wen=1: dout <= mux_out as sampled just before the edge.
- rst=0, rising clk, wen=0: dout holds.
- Reset deasserted coincident with an edge: that edge is ignored (reset wins). The first capture occurs on the following edge.
- Reset asserted mid-operation: dout returns to RESET_VAL without waiting for the clock.
- Latency: key/lut change -> mux_out 0 cycles; -> dout 1 cycle (with wen=1).
- No internal arithmetic; widths pass through unchanged, with no truncation or extension.
- Two instances may be chained (npc -> pc) to form a 2-stage delay; each stage adds exactly 1 cycle.

Test Plan:
- Reset: assert rst asynchronously (no clk edge) with dout=0x12345678 -> dout=0x80000000 immediately. Hold rst for 3 edges -> dout stays 0x80000000.
- Select key 0: lut={1'b0,0x80000004,1'b1,0x80000100}, key=0, wen=1 -> mux_out=0x80000004 and hit=1 immediately; dout=0x80000004 after 1 edge.
- Select key 1: same lut, key=1 -> mux_out=0x80000100; dout=0x80000100 after the next edge. Toggling key each cycle makes dout alternate with exactly 1-cycle lag.
- Miss/default and hold: NR_KEY=2, KEY_LEN=2, keys {2'b00,2'b01}, key=2'b11, default_val=0xDEADBEEF -> hit=0 and mux_out=0xDEADBEEF. With wen=0 across 2 edges, dout is unchanged from its prior value.
- Duplicate keys: entries {0:key1,0xAAAA0000} and {1:key1,0xBBBB0000}, key=1 -> mux_out=0xAAAA0000 (lowest index wins).
- Reset/edge race: drop rst on the same timestep as a rising edge with key=1 -> dout stays 0x80000000 on that edge and becomes 0x80000100 on the next edge.
